// File: rtl/imageline_bus_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imageline_bus_master_if                                            |
// | Avalon-MM register-port bundle between bus master and imageline.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface imageline_bus_master_if;
  logic [10:0] address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/imageline_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imageline_bus_master                                               |
// | Avalon-MM master: single register commands plus an 11-write        |
// | coefficient/config load sequence for the imageline filter slave.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module imageline_bus_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_cmd_valid,
  output logic              o_cmd_ready,
  input  wire logic         i_cmd_write,
  input  wire logic [10:0]  i_cmd_address,
  input  wire logic [31:0]  i_cmd_writedata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_readdata,
  output logic              o_resp_error,
  input  wire logic         i_load_start,
  input  wire logic [319:0] i_coef_in,
  input  wire logic [31:0]  i_filter_config_in,
  output logic              o_load_busy,
  output logic              o_load_done,
  output logic              o_load_error,
  imageline_bus_master_if.master bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_xfer = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [3:0]         c_last_idx = 4'd10;

  logic [1:0]         r_state;
  logic [c_to_w-1:0]  r_to_cnt;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic [3:0]         r_idx;
  logic               r_is_load;
  logic               r_err;
  logic               r_cs;
  logic               r_rd;
  logic               r_wr;
  logic [10:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_cmd_ready;
  logic               r_resp_valid;
  logic               r_resp_error;
  logic               r_load_busy;
  logic               r_load_done;
  logic               r_load_error;
  // Words 0..9 are kernel coefficients + weight sum, word 10 is filter config.
  logic [31:0]        r_word [11];

  logic [3:0]         w_idx_nxt;
  logic [10:0]        w_ld_addr;
  logic [31:0]        w_ld_data;

  always_comb begin
    w_idx_nxt = r_idx + 4'd1;
    w_ld_addr = (w_idx_nxt == c_last_idx) ? 11'd4 : (11'd5 + {7'd0, w_idx_nxt});
    w_ld_data = r_word[w_idx_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_idx        <= '0;
      r_is_load    <= 1'b0;
      r_err        <= 1'b0;
      r_cs         <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cmd_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      for (int k = 0; k < 11; k++) r_word[k] <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (i_load_start) begin
            for (int k = 0; k < 10; k++) r_word[k] <= i_coef_in[32*k +: 32];
            r_word[10]  <= i_filter_config_in;
            r_idx       <= '0;
            r_is_load   <= 1'b1;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_cs        <= 1'b1;
            r_wr        <= 1'b1;
            r_rd        <= 1'b0;
            r_addr      <= 11'd5;
            r_wdata     <= i_coef_in[31:0];
            r_load_busy <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= c_st_xfer;
          end else if (i_cmd_valid && r_cmd_ready) begin
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_cs        <= 1'b1;
            r_wr        <= i_cmd_write;
            r_rd        <= ~i_cmd_write;
            r_addr      <= i_cmd_address;
            r_wdata     <= i_cmd_writedata;
            r_rdata     <= '0;
            r_cmd_ready <= 1'b0;
            r_state     <= c_st_xfer;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        c_st_xfer: begin
          if (!bus.waitrequest || (r_to_cnt == c_to_last)) begin
            if (!bus.waitrequest && r_rd) r_rdata <= bus.readdata;
            if (bus.waitrequest) r_err <= 1'b1;
            r_cs      <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_state   <= c_st_gap;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        c_st_gap: begin
          // The slave starts a transfer on a chipselect rising edge, so
          // chipselect must stay low for the whole gap before the next write.
          if (r_gap_cnt == c_gap_last) begin
            if (r_is_load && (r_idx != c_last_idx)) begin
              r_idx    <= w_idx_nxt;
              r_cs     <= 1'b1;
              r_wr     <= 1'b1;
              r_addr   <= w_ld_addr;
              r_wdata  <= w_ld_data;
              r_to_cnt <= '0;
              r_state  <= c_st_xfer;
            end else begin
              if (r_is_load) begin
                r_load_done  <= 1'b1;
                r_load_error <= r_err;
                r_load_busy  <= 1'b0;
              end else begin
                r_resp_valid <= 1'b1;
                r_resp_error <= r_err;
              end
              r_state <= c_st_done;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        c_st_done: begin
          r_is_load   <= 1'b0;
          r_idx       <= '0;
          r_cmd_ready <= 1'b1;
          r_state     <= c_st_idle;
        end

        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.address    = r_addr;
  assign bus.chipselect = r_cs;
  assign bus.read       = r_rd;
  assign bus.write      = r_wr;
  assign bus.writedata  = r_wdata;

  assign o_cmd_ready     = r_cmd_ready;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_readdata = r_rdata;
  assign o_resp_error    = r_resp_error;
  assign o_load_busy     = r_load_busy;
  assign o_load_done     = r_load_done;
  assign o_load_error    = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_imageline_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imageline_bus_master                                            |
// | Directed bench with a waitrequest-programmable Avalon slave model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_imageline_bus_master;
  localparam int TIMEOUT = 8;
  localparam int GAP     = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_cmd_valid = 1'b0;
  logic         i_cmd_write = 1'b0;
  logic [10:0]  i_cmd_address = '0;
  logic [31:0]  i_cmd_writedata = '0;
  logic         i_load_start = 1'b0;
  logic [319:0] i_coef_in = '0;
  logic [31:0]  i_filter_config_in = '0;
  logic         o_cmd_ready, o_resp_valid, o_resp_error;
  logic [31:0]  o_resp_readdata;
  logic         o_load_busy, o_load_done, o_load_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imageline_bus_master_if bus();

  imageline_bus_master #(.TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_cmd_valid        (i_cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_write        (i_cmd_write),
    .i_cmd_address      (i_cmd_address),
    .i_cmd_writedata    (i_cmd_writedata),
    .o_resp_valid       (o_resp_valid),
    .o_resp_readdata    (o_resp_readdata),
    .o_resp_error       (o_resp_error),
    .i_load_start       (i_load_start),
    .i_coef_in          (i_coef_in),
    .i_filter_config_in (i_filter_config_in),
    .o_load_busy        (o_load_busy),
    .o_load_done        (o_load_done),
    .o_load_error       (o_load_error),
    .bus                (bus.master)
  );

  // Slave model: holds waitrequest for wait_n edges of each chipselect window.
  int          wait_n   = 0;
  logic        stuck    = 1'b0;
  logic [31:0] rd_value = '0;
  int          s_cnt    = 0;
  always @(posedge clk) s_cnt <= bus.chipselect ? s_cnt + 1 : 0;
  assign bus.waitrequest = bus.chipselect && (stuck || (s_cnt < wait_n));
  assign bus.readdata    = (bus.chipselect && !bus.waitrequest) ? rd_value : 32'hDEAD_BEEF;

  // Bus monitor: one record per chipselect window.
  logic [10:0] w_addr [64];
  logic [31:0] w_data [64];
  logic        w_wr   [64];
  int          w_len  [64];
  int          w_gap  [64];
  int          n_win    = 0;
  int          low_run  = 0;
  logic        prev_cs  = 1'b0;
  int          unstable = 0;
  int          badrw    = 0;
  int          resp_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (bus.chipselect) begin
      if (!prev_cs) begin
        if (n_win < 64) begin
          w_addr[n_win] = bus.address;
          w_data[n_win] = bus.writedata;
          w_wr[n_win]   = bus.write;
          w_len[n_win]  = 0;
          w_gap[n_win]  = low_run;
        end
        n_win++;
      end
      if (n_win <= 64) begin
        w_len[n_win-1]++;
        if (bus.address !== w_addr[n_win-1] || bus.writedata !== w_data[n_win-1]) unstable++;
      end
      if (bus.read === bus.write) badrw++;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_cs = bus.chipselect;
    if (o_resp_valid) resp_cnt++;
    if (o_load_done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [10:0] a, input logic [31:0] d);
    int guard;
    tick();
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_address = a; i_cmd_writedata = d;
    guard = 0;
    while (!o_cmd_ready && guard < 300) begin tick(); guard++; end
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!o_resp_valid && lat < 300) begin tick(); lat++; end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_load_done && lat < 600) begin tick(); lat++; end
  endtask

  task automatic start_load();
    tick();
    for (int k = 0; k < 10; k++) i_coef_in[32*k +: 32] = 32'h100 + k;
    i_filter_config_in = 32'hA5;
    i_load_start = 1'b1;
    @(posedge clk);
    #1 i_load_start = 1'b0;
    i_coef_in = {10{32'hFFFF_0000}};
    i_filter_config_in = 32'h0BAD_0BAD;
  endtask

  task automatic check_load_windows(input int b, input int len);
    logic [10:0] ea;
    logic [31:0] ed;
    for (int k = 0; k < 11; k++) begin
      ea = (k == 10) ? 11'd4 : 11'(5 + k);
      ed = (k == 10) ? 32'hA5 : 32'(32'h100 + k);
      checks++;
      if (b + k >= 64 || w_addr[b+k] !== ea || w_data[b+k] !== ed || w_wr[b+k] !== 1'b1 || w_len[b+k] != len) begin
        errors++;
        $display("FAIL load_xfer%0d: got addr=%0d data=%h wr=%b len=%0d expected addr=%0d data=%h wr=1 len=%0d",
                 k, w_addr[b+k], w_data[b+k], w_wr[b+k], w_len[b+k], ea, ed, len);
      end
      if (k > 0) begin
        checks++;
        if (w_gap[b+k] < GAP) begin
          errors++; $display("FAIL load_gap%0d: got %0d low cycles expected >= %0d", k, w_gap[b+k], GAP);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.chipselect !== 1'b0 || bus.read !== 1'b0 || bus.write !== 1'b0) begin
      errors++; $display("FAIL reset_bus: got cs=%b rd=%b wr=%b expected 0", bus.chipselect, bus.read, bus.write); end
    checks++; if (o_cmd_ready !== 1'b0 || o_resp_valid !== 1'b0 || o_load_busy !== 1'b0 || o_load_done !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b resp=%b busy=%b done=%b expected 0",
                         o_cmd_ready, o_resp_valid, o_load_busy, o_load_done); end
    rst = 1'b0;
    tick();
    checks++; if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b expected 1", o_cmd_ready); end
  endtask

  task automatic test_single_write();
    int b, r0, u0, lat;
    wait_n = 2; b = n_win; r0 = resp_cnt; u0 = unstable;
    issue_cmd(1'b1, 11'd4, 32'h0000_0012);
    wait_resp(lat);
    checks++; if (lat != 3 + 2 + GAP - 1) begin
      errors++; $display("FAIL write_latency: got %0d expected %0d", lat, 3 + 2 + GAP - 1); end
    checks++; if (o_resp_error !== 1'b0 || o_resp_readdata !== 32'h0) begin
      errors++; $display("FAIL write_resp: got err=%b data=%h expected err=0 data=0", o_resp_error, o_resp_readdata); end
    repeat (4) tick();
    checks++; if (n_win - b != 1 || w_addr[b] !== 11'd4 || w_data[b] !== 32'h12 || w_wr[b] !== 1'b1 || w_len[b] != 3) begin
      errors++; $display("FAIL write_window: got n=%0d addr=%0d data=%h wr=%b len=%0d expected n=1 addr=4 data=12 wr=1 len=3",
                         n_win - b, w_addr[b], w_data[b], w_wr[b], w_len[b]); end
    checks++; if (unstable != u0 || resp_cnt - r0 != 1) begin
      errors++; $display("FAIL write_stable_pulse: got unstable=%0d pulses=%0d expected 0 and 1", unstable - u0, resp_cnt - r0); end
  endtask

  task automatic test_single_read();
    int b, lat;
    wait_n = 0; rd_value = 32'h0000_001D; b = n_win;
    issue_cmd(1'b0, 11'd1, 32'h0);
    wait_resp(lat);
    checks++; if (o_resp_readdata !== 32'h1D || o_resp_error !== 1'b0) begin
      errors++; $display("FAIL read_data: got data=%h err=%b expected data=1d err=0", o_resp_readdata, o_resp_error); end
    checks++; if (bus.chipselect !== 1'b0 || bus.read !== 1'b0 || low_run < 1) begin
      errors++; $display("FAIL read_release: got cs=%b rd=%b low=%0d expected 0 0 >=1", bus.chipselect, bus.read, low_run); end
    checks++; if (o_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL read_ready_in_done: got %b expected 0", o_cmd_ready); end
    checks++; if (w_addr[b] !== 11'd1 || w_wr[b] !== 1'b0 || w_len[b] != 1) begin
      errors++; $display("FAIL read_window: got addr=%0d wr=%b len=%0d expected 1 0 1", w_addr[b], w_wr[b], w_len[b]); end
    tick();
    checks++; if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL read_ready_after: got %b expected 1", o_cmd_ready); end
  endtask

  task automatic test_load_sequence();
    int b, d0, lat, bad;
    wait_n = 1; b = n_win; d0 = done_cnt; bad = badrw;
    start_load();
    tick();
    checks++; if (o_load_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL load_busy_start: got busy=%b ready=%b expected 1 0", o_load_busy, o_cmd_ready); end
    wait_done(lat);
    checks++; if (o_load_done !== 1'b1 || o_load_error !== 1'b0 || o_load_busy !== 1'b0) begin
      errors++; $display("FAIL load_done: got done=%b err=%b busy=%b expected 1 0 0", o_load_done, o_load_error, o_load_busy); end
    repeat (3) tick();
    checks++; if (n_win - b != 11 || done_cnt - d0 != 1 || badrw != bad) begin
      errors++; $display("FAIL load_count: got windows=%0d done=%0d badrw=%0d expected 11 1 0", n_win - b, done_cnt - d0, badrw - bad); end
    check_load_windows(b, 2);
  endtask

  task automatic test_timeout();
    int b, lat;
    stuck = 1'b1; b = n_win;
    issue_cmd(1'b1, 11'd7, 32'h55);
    wait_resp(lat);
    checks++; if (o_resp_valid !== 1'b1 || o_resp_error !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got valid=%b err=%b expected 1 1", o_resp_valid, o_resp_error); end
    checks++; if (w_len[b] != TIMEOUT) begin
      errors++; $display("FAIL timeout_len: got %0d expected %0d", w_len[b], TIMEOUT); end
    stuck = 1'b0;
    tick();
    checks++; if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_idle: got ready=%b expected 1", o_cmd_ready); end
    rd_value = 32'h0000_0033;
    issue_cmd(1'b0, 11'd2, 32'h0);
    wait_resp(lat);
    checks++; if (o_resp_error !== 1'b0 || o_resp_readdata !== 32'h33) begin
      errors++; $display("FAIL timeout_recover: got err=%b data=%h expected 0 33", o_resp_error, o_resp_readdata); end
  endtask

  task automatic test_simultaneous();
    int b, lat, viol, guard;
    wait_n = 0; b = n_win; viol = 0;
    tick();
    for (int k = 0; k < 10; k++) i_coef_in[32*k +: 32] = 32'h100 + k;
    i_filter_config_in = 32'hA5;
    i_load_start = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_address = 11'd2; i_cmd_writedata = 32'h77;
    @(posedge clk);
    #1 i_load_start = 1'b0;
    lat = 0;
    while (!o_load_done && lat < 600) begin tick(); lat++; if (o_cmd_ready) viol++; end
    checks++; if (o_load_done !== 1'b1 || viol != 0) begin
      errors++; $display("FAIL sim_load_first: got done=%b ready_violations=%0d expected 1 0", o_load_done, viol); end
    guard = 0;
    while (!o_cmd_ready && guard < 50) begin tick(); guard++; end
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    wait_resp(lat);
    checks++; if (o_resp_valid !== 1'b1 || o_resp_error !== 1'b0) begin
      errors++; $display("FAIL sim_cmd_resp: got valid=%b err=%b expected 1 0", o_resp_valid, o_resp_error); end
    checks++; if (n_win - b != 12 || w_addr[b+11] !== 11'd2 || w_data[b+11] !== 32'h77 || w_wr[b+11] !== 1'b1) begin
      errors++; $display("FAIL sim_cmd_after: got n=%0d addr=%0d data=%h wr=%b expected 12 2 77 1",
                         n_win - b, w_addr[b+11], w_data[b+11], w_wr[b+11]); end
    check_load_windows(b, 1);
  endtask

  task automatic test_reset_mid_load();
    int b, d0, guard, lat;
    wait_n = 3; b = n_win; d0 = done_cnt;
    start_load();
    guard = 0;
    while (n_win - b < 3 && guard < 200) begin tick(); guard++; end
    checks++; if (bus.chipselect !== 1'b1 || o_load_busy !== 1'b1 || w_addr[b+2] !== 11'd7) begin
      errors++; $display("FAIL midrst_third: got cs=%b busy=%b addr=%0d expected 1 1 7", bus.chipselect, o_load_busy, w_addr[b+2]); end
    rst = 1'b1;
    tick();
    checks++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0 || o_load_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: got cs=%b wr=%b busy=%b expected 0 0 0", bus.chipselect, bus.write, o_load_busy); end
    tick();
    rst = 1'b0;
    repeat (40) tick();
    checks++; if (done_cnt != d0 || n_win - b != 3) begin
      errors++; $display("FAIL midrst_quiet: got done=%0d windows=%0d expected 0 3", done_cnt - d0, n_win - b); end
    wait_n = 0; b = n_win;
    start_load();
    wait_done(lat);
    checks++; if (o_load_done !== 1'b1 || o_load_error !== 1'b0 || n_win - b != 11) begin
      errors++; $display("FAIL midrst_restart: got done=%b err=%b windows=%0d expected 1 0 11", o_load_done, o_load_error, n_win - b); end
    check_load_windows(b, 1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_load_sequence();
    test_timeout();
    test_simultaneous();
    test_reset_mid_load();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
